led_seq: RTL



---
 rtl/led_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/led_seq.sv
// Eight-LED pattern sequencer: four display programs, one step every DIV clocks.
// Optional PWM brightness gating when LED_SEQ_PWM_EN is defined.
module led_seq #(
  parameter int unsigned DIV = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
`ifdef LED_SEQ_PWM_EN
  input  logic [2:0] bright,
`endif
  output logic       busy,
  output logic       step,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5,
  output logic       LED6,
  output logic       LED7
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(DIV - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [7:0]    pattern_q, pattern_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    mode_q, mode_d;
  logic          dir_up_q, dir_up_d;
  logic [7:0]    leds;

  function automatic logic [7:0] init_pattern(input logic [1:0] m);
    case (m)
      2'd0:    return 8'h00;
      2'd3:    return 8'hFF;
      default: return 8'h01;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    presc_d   = presc_q;
    mode_d    = mode_q;
    dir_up_d  = dir_up_q;
    step      = 1'b0;
    case (state_q)
      StIdle: begin
        pattern_d = 8'h00;
        presc_d   = '0;
        dir_up_d  = 1'b1;
        if (start && !stop) begin
          state_d   = StRun;
          mode_d    = mode;
          pattern_d = init_pattern(mode);
        end
      end
      StRun: begin
        if (stop) begin
          state_d   = StIdle;
          pattern_d = 8'h00;
          presc_d   = '0;
          dir_up_d  = 1'b1;
        end else if (start) begin
          mode_d    = mode;
          pattern_d = init_pattern(mode);
          presc_d   = '0;
          dir_up_d  = 1'b1;
        end else if (presc_q == PrescLast) begin
          presc_d = '0;
          step    = 1'b1;
          case (mode_q)
            2'd0: pattern_d = pattern_q + 8'd1;
            2'd1: pattern_d = {pattern_q[6:0], pattern_q[7]};
            2'd2: begin
              pattern_d = dir_up_q ? {pattern_q[6:0], 1'b0} : {1'b0, pattern_q[7:1]};
              // Direction flips on arriving at either end so each end shows once.
              if (pattern_d == 8'h80) dir_up_d = 1'b0;
              if (pattern_d == 8'h01) dir_up_d = 1'b1;
            end
            default: pattern_d = ~pattern_q;
          endcase
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst) step = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pattern_q <= 8'h00;
      presc_q   <= '0;
      mode_q    <= 2'd0;
      dir_up_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      dir_up_q  <= dir_up_d;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [2:0] pwm_q, pwm_d;
  logic [7:0] led_q, led_d;

  // Gate against the counter value that will be live alongside the new pattern.
  always_comb begin
    pwm_d = pwm_q + 3'd1;
    led_d = pattern_d & {8{pwm_d <= bright}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= 3'd0;
      led_q <= 8'h00;
    end else begin
      pwm_q <= pwm_d;
      led_q <= led_d;
    end
  end

  assign leds = led_q;
`else
  assign leds = pattern_q;
`endif

  assign busy = (state_q == StRun);
  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = leds;

endmodule
